// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and widths.
// Imported by the fetch interface, hold buffer and stage.
package mips_pkg;

    localparam int PC_W = 8;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control in, memory port, IF/ID out.
// master = fetch stage, slave = pipeline/memory side.
interface fetch_stage_if;
    import mips_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_target;
    logic               halt_req;
    logic [INSTR_W-1:0] instruct_in;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc_plus4;
    logic               ifid_valid;
    logic               halted;

    modport master (
        input  stall, redirect_valid, redirect_target,
        input  halt_req, instruct_in,
        output pc, ifid_instr, ifid_pc_plus4,
        output ifid_valid, halted
    );

    modport slave (
        output stall, redirect_valid, redirect_target,
        output halt_req, instruct_in,
        input  pc, ifid_instr, ifid_pc_plus4,
        input  ifid_valid, halted
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer that parks the in-flight word
// during a stall and bypasses the live word otherwise.
module fetch_hold_buf
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               hold_valid,
    output logic               avail_valid,
    output logic [INSTR_W-1:0] avail_instr,
    output logic [PC_W-1:0]    avail_pc
);

    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc;

    // Capture only the first in-flight word of a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (load && in_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_instr <= in_instr;
            hold_pc    <= in_pc;
        end
    end

    // Held word takes precedence over the live memory word.
    always_comb begin
        avail_valid = hold_valid | in_valid;
        avail_instr = hold_valid ? hold_instr : in_instr;
        avail_pc    = hold_valid ? hold_pc : in_pc;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-flight slot, IF/ID register,
// stall realignment, redirect flush and halt drain.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t       state, state_n;
    logic [PC_W-1:0]    pc_q, pc_n;
    logic               if_valid, if_valid_n;
    logic [PC_W-1:0]    if_pc, if_pc_n;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_n;
    logic [PC_W-1:0]    ifid_pc4_q, ifid_pc4_n;
    logic               ifid_valid_q, ifid_valid_n;
    logic               hold_load, hold_clear, hold_valid;
    logic               avail_valid;
    logic [INSTR_W-1:0] avail_instr;
    logic [PC_W-1:0]    avail_pc;

    fetch_hold_buf u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (hold_load),
        .clear       (hold_clear),
        .in_valid    (if_valid),
        .in_instr    (bus.instruct_in),
        .in_pc       (if_pc),
        .hold_valid  (hold_valid),
        .avail_valid (avail_valid),
        .avail_instr (avail_instr),
        .avail_pc    (avail_pc)
    );

    // Next-state: redirect beats stall beats a normal edge.
    always_comb begin
        state_n      = state;
        pc_n         = pc_q;
        if_valid_n   = if_valid;
        if_pc_n      = if_pc;
        ifid_instr_n = ifid_instr_q;
        ifid_pc4_n   = ifid_pc4_q;
        ifid_valid_n = ifid_valid_q;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        if (bus.redirect_valid) begin
            pc_n         = {bus.redirect_target[PC_W-1:2], 2'b00};
            if_valid_n   = 1'b0;
            hold_clear   = 1'b1;
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_WORD;
            state_n      = RUN;
        end else if (state == HALTED) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_WORD;
        end else if (bus.stall) begin
            hold_load = 1'b1;
            if (state == RUN) begin
                // Memory re-reads pc, so the word is refetched.
                if_pc_n    = pc_q;
                if_valid_n = 1'b1;
            end else if (if_valid && !hold_valid) begin
                if_valid_n = 1'b0;
            end
        end else begin
            hold_clear   = 1'b1;
            ifid_valid_n = avail_valid;
            ifid_instr_n = avail_valid ? avail_instr : NOP_WORD;
            if (avail_valid)
                ifid_pc4_n = avail_pc + PC_W'(4);
            if (state == RUN) begin
                if (bus.halt_req) begin
                    state_n = DRAIN;
                    if (!hold_valid)
                        if_valid_n = 1'b0;
                end else begin
                    if_pc_n    = pc_q;
                    if_valid_n = 1'b1;
                    pc_n       = pc_q + PC_W'(4);
                end
            end else begin
                if (!hold_valid)
                    if_valid_n = 1'b0;
                if (!avail_valid)
                    state_n = HALTED;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= RUN;
        else
            state <= state_n;
    end

    // PC, in-flight slot and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_n;
            if_valid     <= if_valid_n;
            if_pc        <= if_pc_n;
            ifid_instr_q <= ifid_instr_n;
            ifid_pc4_q   <= ifid_pc4_n;
            ifid_valid_q <= ifid_valid_n;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_pc_plus4 = ifid_pc4_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.halted        = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a registered
// instruction memory holding 32'hABCD_00aa at address aa.
module tb_fetch_stage;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [7:0] a);
        return {24'hABCD_00, a};
    endfunction

    always @(posedge clk)
        bus.instruct_in <= w({bus.pc[7:2], 2'b00});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.pc !== 8'd0) begin
            failures++;
            $display("FAIL reset_pc got=%h want=00", bus.pc);
        end
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_ifid got=%b/%h want=0/0",
                     bus.ifid_valid, bus.ifid_instr);
        end
        checks++;
        if (bus.ifid_pc_plus4 !== 8'd0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_misc got=%h/%b want=00/0",
                     bus.ifid_pc_plus4, bus.halted);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        tick();
        checks++;
        if (bus.pc !== 8'd4 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL seq_e1 got=%h/%b want=04/0",
                     bus.pc, bus.ifid_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.ifid_instr !== w(8'(4 * i)) ||
                bus.ifid_pc_plus4 !== 8'(4 * i + 4) ||
                bus.ifid_valid !== 1'b1 ||
                bus.pc !== 8'(4 * i + 8)) begin
                failures++;
                $display("FAIL seq_w%0d got=%h/%h/%b pc=%h", i,
                         bus.ifid_instr, bus.ifid_pc_plus4,
                         bus.ifid_valid, bus.pc);
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ifid_instr !== w(8'd4) || bus.pc !== 8'd12 ||
                bus.ifid_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h pc=%h want=%h pc=0c",
                         i, bus.ifid_instr, bus.pc, w(8'd4));
            end
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.ifid_instr !== w(8'(8 + 4 * i)) ||
                bus.ifid_pc_plus4 !== 8'(12 + 4 * i) ||
                bus.ifid_valid !== 1'b1 ||
                bus.pc !== 8'(16 + 4 * i)) begin
                failures++;
                $display("FAIL stall_rel%0d got=%h/%h/%b pc=%h", i,
                         bus.ifid_instr, bus.ifid_pc_plus4,
                         bus.ifid_valid, bus.pc);
            end
        end
    endtask

    task automatic test_halt();
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        checks++;
        if (bus.ifid_instr !== w(8'd16) || bus.ifid_pc_plus4 !== 8'd20 ||
            bus.ifid_valid !== 1'b1 || bus.pc !== 8'd20 ||
            bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_edge got=%h/%h/%b pc=%h h=%b",
                     bus.ifid_instr, bus.ifid_pc_plus4,
                     bus.ifid_valid, bus.pc, bus.halted);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0 ||
                bus.pc !== 8'd20) begin
                failures++;
                $display("FAIL halted%0d got h=%b v=%b pc=%h want 1/0/14",
                         i, bus.halted, bus.ifid_valid, bus.pc);
            end
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 8'd0;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.halted !== 1'b0 || bus.pc !== 8'd0 ||
            bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL resume got h=%b pc=%h v=%b want 0/00/0",
                     bus.halted, bus.pc, bus.ifid_valid);
        end
        tick();
        tick();
        checks++;
        if (bus.ifid_instr !== w(8'd0) || bus.ifid_pc_plus4 !== 8'd4 ||
            bus.ifid_valid !== 1'b1 || bus.pc !== 8'd8) begin
            failures++;
            $display("FAIL resume_w0 got=%h/%h/%b pc=%h",
                     bus.ifid_instr, bus.ifid_pc_plus4,
                     bus.ifid_valid, bus.pc);
        end
    endtask

    task automatic test_redirect_stall();
        bus.stall           = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 8'h41;
        tick();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.pc !== 8'h40 || bus.ifid_valid !== 1'b0 ||
            bus.ifid_instr !== 32'h0) begin
            failures++;
            $display("FAIL redir_e1 got pc=%h v=%b i=%h want 40/0/0",
                     bus.pc, bus.ifid_valid, bus.ifid_instr);
        end
        tick();
        checks++;
        if (bus.pc !== 8'h44 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_e2 got pc=%h v=%b want 44/0",
                     bus.pc, bus.ifid_valid);
        end
        tick();
        checks++;
        if (bus.ifid_instr !== w(8'h40) || bus.ifid_pc_plus4 !== 8'h44 ||
            bus.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_w got=%h/%h/%b want=%h/44/1",
                     bus.ifid_instr, bus.ifid_pc_plus4,
                     bus.ifid_valid, w(8'h40));
        end
    endtask

    task automatic test_wrap();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 8'd252;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.pc !== 8'd252) begin
            failures++;
            $display("FAIL wrap_pc0 got=%h want=fc", bus.pc);
        end
        tick();
        checks++;
        if (bus.pc !== 8'd0) begin
            failures++;
            $display("FAIL wrap_pc1 got=%h want=00", bus.pc);
        end
        tick();
        checks++;
        if (bus.pc !== 8'd4 || bus.ifid_instr !== w(8'd252) ||
            bus.ifid_pc_plus4 !== 8'd0 || bus.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_w got pc=%h %h/%h/%b",
                     bus.pc, bus.ifid_instr, bus.ifid_pc_plus4,
                     bus.ifid_valid);
        end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        bus.stall = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 8'd0 || bus.ifid_valid !== 1'b0 ||
            bus.ifid_instr !== 32'h0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL areset got pc=%h v=%b i=%h h=%b",
                     bus.pc, bus.ifid_valid, bus.ifid_instr, bus.halted);
        end
        @(negedge clk);
        rst       = 1'b1;
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.pc !== 8'd4 || bus.ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_e1 got pc=%h v=%b want 04/0",
                     bus.pc, bus.ifid_valid);
        end
        tick();
        checks++;
        if (bus.ifid_instr !== w(8'd0) || bus.ifid_pc_plus4 !== 8'd4 ||
            bus.ifid_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_w0 got=%h/%h/%b want=%h/04/1",
                     bus.ifid_instr, bus.ifid_pc_plus4,
                     bus.ifid_valid, w(8'd0));
        end
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        rst                 = 1'b0;
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 8'd0;
        bus.halt_req        = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_halt();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the MIPS pipeline.
- Owns the program counter, which drives the instruction memory address.
- Realigns the 32-bit word the memory returns one cycle later and loads it into the IF/ID pipeline register.
- Supports stall (with a one-entry hold buffer so no instruction is lost), redirect/flush for branch and jump, and a halt/drain sequence.

Parameters:
PC_W, 8, PC/address width; byte address matching the 256-byte instruction memory
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
NOP_WORD, 32'h0000_0000, value placed in ifid_instr whenever the slot is invalid

Ports:
clk  in  1  sole clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
stall  in  1  decode/hazard stall; freezes PC and IF/ID
redirect_valid  in  1  branch taken or jump; flush and restart fetch
redirect_target  in  PC_W  new fetch address; bits [1:0] ignored (forced 00)
halt_req  in  1  one-cycle request to stop fetching
instruct_in  in  INSTR_W  memory data for the address presented on the previous edge
pc  out  PC_W  fetch address to instruction memory (register output)
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc_plus4  out  PC_W  IF/ID address of that instruction + 4
ifid_valid  out  1  IF/ID slot holds a real instruction
halted  out  1  high in HALTED state

Behaviour:
- Memory model: a registered read. instruct_in in cycle n+1 = mem word at the pc sampled at edge n.
- Internal state: in-flight slot (if_valid, if_pc), hold buffer (hold_valid, hold_instr, hold_pc), state.
- State encoding: RUN, DRAIN, HALTED.
- Reset (rst=0) values:
  - pc=RESET_PC; if_valid=0; hold_valid=0.
  - ifid_valid=0, ifid_instr=NOP_WORD, ifid_pc_plus4=0; halted=0; state=RUN.
  - First edge after release: if_pc<=RESET_PC, if_valid<=1, pc<=RESET_PC+4.
- "Available" instruction: the hold buffer if hold_valid, else (instruct_in, if_pc) if if_valid, else none.
- Edge priority: redirect > stall > normal. halt_req is evaluated only on normal edges.
- Redirect (any state, stall ignored):
  - pc<=target&~3; if_valid<=0; hold_valid<=0.
  - ifid_valid<=0, ifid_instr<=NOP_WORD; state<=RUN.
  - First valid IF/ID appears 2 edges later.
- Stall (no redirect):
  - pc and all IF/ID outputs hold.
  - If if_valid and !hold_valid: hold<=(instruct_in, if_pc), hold_valid<=1.
  - In RUN: if_pc<=pc, if_valid<=1, so the memory re-reads pc and that word is refetched, not lost.
- Normal RUN edge:
  - IF/ID<=available: ifid_instr=word, ifid_pc_plus4=its pc+4, ifid_valid=1. If nothing is available, ifid_valid=0 and ifid_instr=NOP_WORD.
  - hold_valid<=0; if_pc<=pc; if_valid<=1; pc<=pc+4.
  - Net result: back-to-back instructions, zero bubbles after stall release.
- halt_req on a normal RUN edge:
  - IF/ID loads as above; pc holds; if_valid<=0 unless hold_valid, so the current in-flight word survives. In that case if_pc<=pc is not done.
  - state<=DRAIN.
- DRAIN:
  - No new fetches; pc frozen; stall honoured.
  - Each normal edge delivers the available instruction.
  - When nothing remains (hold_valid=0, if_valid=0) on a normal edge: ifid_valid<=0, state<=HALTED.
- HALTED:
  - halted=1; ifid_valid=0; pc frozen.
  - stall and halt_req are ignored.
  - Only redirect or reset leaves the state.
- Arithmetic: modulo 2^PC_W. pc=252 increments to 0; ifid_pc_plus4 of the word at 252 is 0.
- Simultaneous events:
  - redirect+stall → redirect.
  - redirect+halt_req → redirect; halt dropped.
  - stall+halt_req → halt_req dropped; the requester must re-assert.
- Reset mid-operation: takes effect immediately; all in-flight and hold contents are discarded.

Decomposition:
- Shared package (mips_pkg): PC_W, INSTR_W, NOP_WORD, fetch_state_t enum {RUN, DRAIN, HALTED}.
- One natural sub-module: fetch_hold_buf (single-entry capture/bypass register for stall realignment).
- PC and IF/ID logic stay in fetch_stage.

Test Plan:
- Sequential run: memory words W0..W3 at 0,4,8,12; reset release. Required response: pc=0,4,8,12,…; ifid_instr=W0 at edge 2, then W1, W2 on consecutive edges; ifid_pc_plus4=4,8,12.
- Stall 3 cycles while pc=12 (in-flight W2): IF/ID holds W1 for all 3 cycles. After release, W2 then W3 on consecutive edges, with no duplicate and no gap.
- Redirect to 0x41 while stalled: pc=0x40 next cycle; ifid_valid=0 for 2 edges; then the word at 0x40 with ifid_pc_plus4=0x44.
- Wrap: redirect to 252. Required response: pc sequence 252,0,4; ifid_pc_plus4 of the word at 252 is 0.
- Halt: pulse halt_req at pc=20. Required response: the words at 12 and 16 still delivered; pc stays 20; halted=1 after drain; ifid_valid=0. A later redirect to 0 resumes RUN.
- Async reset: drop rst mid-stall with hold_valid=1, without a clock edge. Required response: pc=0, ifid_valid=0, ifid_instr=0, halted=0 immediately; the held word is never delivered.
